// File: rtl/pwm_regs_pkg.sv
// pwm_regs_pkg: definitions shared by instr_decode and the PWM register file.
//   - widths of the SPI byte and of the register address
//   - command byte field positions
//   - transaction FSM state encoding (2 bits)
//   - register map addresses
package pwm_regs_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  // Command byte layout: {rw, hi_sel, addr[5:0]}
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_HI_BIT   = 6;
  localparam int CMD_ADDR_LSB = 0;

  // Transaction FSM states
  typedef enum logic [1:0] {
    ST_CMD   = 2'd0,  // waiting for a command byte
    ST_RD    = 2'd1,  // single read-strobe cycle
    ST_RDATA = 2'd2,  // read data shifting out; incoming byte is a dummy
    ST_WDATA = 2'd3   // waiting for the write data byte
  } state_e;

  // Register map
  localparam logic [ADDR_W_DEF-1:0] REG_CTRL   = 6'h00;
  localparam logic [ADDR_W_DEF-1:0] REG_PERIOD = 6'h01;
  localparam logic [ADDR_W_DEF-1:0] REG_DUTY0  = 6'h02;
  localparam logic [ADDR_W_DEF-1:0] REG_DUTY1  = 6'h03;
  localparam logic [ADDR_W_DEF-1:0] REG_DUTY2  = 6'h04;
  localparam logic [ADDR_W_DEF-1:0] REG_DUTY3  = 6'h05;
  localparam logic [ADDR_W_DEF-1:0] REG_STATUS = 6'h3F;

endpackage

// File: rtl/instr_decode_if.sv
// instr_decode_if: bundles the SPI-bridge byte interface and the register
// file strobe interface seen by instr_decode.
//   master : the decoder (consumes bytes, drives register strobes/address)
//   slave  : the environment (spi_bridge + register file)
interface instr_decode_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  // spi_bridge side
  logic              cs_n;
  logic              byte_sync;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  // register file side
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic              hi_sel;
  logic [DATA_W-1:0] data_write;
  logic [DATA_W-1:0] data_read;

  modport master (
    input  cs_n, byte_sync, data_in, data_read,
    output data_out, read, write, addr, hi_sel, data_write
  );

  modport slave (
    output cs_n, byte_sync, data_in, data_read,
    input  data_out, read, write, addr, hi_sel, data_write
  );
endinterface

// File: rtl/instr_decode.sv
// instr_decode: turns the 2-byte SPI transaction stream (command, data) into
// single-cycle register read/write strobes.
// Ports:
//   clk, rst_n        peripheral clock, async active-low reset
//   bus (master)      cs_n/byte_sync/data_in in, data_out out (to spi_bridge);
//                     read/write/addr/hi_sel/data_write out, data_read in
//                     (to the register file; data_read is combinational
//                     from addr/hi_sel)
// All outputs are registered and reset to zero.
module instr_decode
  import pwm_regs_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_decode_if.master bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                hi_sel_q, hi_sel_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [DATA_W-1:0]   data_write_q, data_write_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hi_sel_d     = hi_sel_q;
    data_out_d   = data_out_q;
    data_write_d = data_write_q;
    write_d      = 1'b0;

    case (state_q)
      ST_CMD: begin
        if (bus.byte_sync) begin
          addr_d   = bus.data_in[CMD_ADDR_LSB +: ADDR_W];
          hi_sel_d = bus.data_in[CMD_HI_BIT];
          state_d  = bus.data_in[CMD_RW_BIT] ? ST_WDATA : ST_RD;
        end
      end
      ST_RD: begin
        // read strobe is high this cycle, so data_read reflects addr/hi_sel
        data_out_d = bus.data_read;
        state_d    = ST_RDATA;
      end
      ST_RDATA: begin
        if (bus.byte_sync) state_d = ST_CMD;
      end
      ST_WDATA: begin
        if (bus.byte_sync) begin
          write_d      = 1'b1;
          data_write_d = bus.data_in;
          state_d      = ST_CMD;
        end
      end
      default: state_d = ST_CMD;
    endcase

    // cs_n abort wins over the next state, but only after the byte in this
    // cycle has been consumed; the read cycle is never cut short.
    if (bus.cs_n && (state_q != ST_RD)) state_d = ST_CMD;

    // read strobe is registered: high exactly while sitting in ST_RD
    read_d = (state_d == ST_RD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CMD;
      addr_q       <= '0;
      hi_sel_q     <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      data_out_q   <= '0;
      data_write_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hi_sel_q     <= hi_sel_d;
      read_q       <= read_d;
      write_q      <= write_d;
      data_out_q   <= data_out_d;
      data_write_q <= data_write_d;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.hi_sel     = hi_sel_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_write = data_write_q;

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed vector table plus randomized traffic for
// instr_decode, checked against a transaction-level reference model and a
// behavioural register file.
module tb_instr_decode;
  import pwm_regs_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rf_clr = 1'b1;
  always #5 clk = ~clk;

  instr_decode_if #(.ADDR_W(6), .DATA_W(8)) bus();

  instr_decode #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Behavioural register file: 64 x 16-bit, byte addressed by hi_sel
  logic [7:0] rf [64][2];
  assign bus.data_read = rf[bus.addr][bus.hi_sel];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 64; i++) begin
        rf[i][0] <= 8'h00;
        rf[i][1] <= 8'h00;
      end
      rf[5][1] <= 8'hA7;
    end else if (bus.write) begin
      rf[bus.addr][bus.hi_sel] <= bus.data_write;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: tracks where we are in a transaction by what the next
  // byte means, and predicts the outputs after each clock.
  logic       m_read, m_write, m_hi;
  logic [5:0] m_addr;
  logic [7:0] m_dout, m_dw;
  bit         m_rd_now, m_want_dummy, m_want_wdata;

  task automatic model_reset();
    m_read = 0; m_write = 0; m_hi = 0; m_addr = '0; m_dout = '0; m_dw = '0;
    m_rd_now = 0; m_want_dummy = 0; m_want_wdata = 0;
  endtask

  task automatic model_cycle(input logic cs, input logic bs, input logic [7:0] din);
    m_read  = 0;
    m_write = 0;
    if (m_rd_now) begin
      m_dout = rf[m_addr][m_hi];
      m_rd_now = 0;
      m_want_dummy = 1;
    end else if (m_want_dummy) begin
      if (bs || cs) m_want_dummy = 0;
    end else if (m_want_wdata) begin
      if (bs) begin
        m_write = 1; m_dw = din; m_want_wdata = 0;
      end else if (cs) begin
        m_want_wdata = 0;
      end
    end else if (bs) begin
      m_addr = din[5:0];
      m_hi   = din[6];
      if (!cs) begin
        if (din[7]) m_want_wdata = 1;
        else begin m_rd_now = 1; m_read = 1; end
      end
    end
  endtask

  function automatic logic [24:0] dut_vec();
    return {bus.read, bus.write, bus.addr, bus.hi_sel, bus.data_out, bus.data_write};
  endfunction

  function automatic logic [24:0] model_vec();
    return {m_read, m_write, m_addr, m_hi, m_dout, m_dw};
  endfunction

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rd=%b wr=%b addr=%h hi=%b dout=%h dw=%h, want rd=%b wr=%b addr=%h hi=%b dout=%h dw=%h",
               name, act[24], act[23], act[22:17], act[16], act[15:8], act[7:0],
               exp[24], exp[23], exp[22:17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  // One clock: drive at negedge, update model, sample at next negedge.
  task automatic step(input logic cs, input logic bs, input logic [7:0] din);
    bus.cs_n = cs; bus.byte_sync = bs; bus.data_in = din;
    model_cycle(cs, bs, din);
    @(posedge clk);
    @(negedge clk);
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset(input string name);
    bus.cs_n = 1; bus.byte_sync = 0; bus.data_in = '0;
    #2 rst_n = 0;
    #1 chk(name, dut_vec(), 25'd0);
    model_reset();
    @(negedge clk);
    chk({name, "_hold"}, dut_vec(), 25'd0);
    rst_n = 1;
  endtask

  typedef struct {
    logic       cs, bs;
    logic [7:0] din;
    logic       rd, wr;
    logic [5:0] addr;
    logic       hi;
    logic [7:0] dout, dw;
  } vec_t;

  function automatic vec_t mkv(input logic cs, bs, input logic [7:0] din,
                               input logic rd, wr, input logic [5:0] addr,
                               input logic hi, input logic [7:0] dout, dw);
    vec_t v;
    v.cs = cs; v.bs = bs; v.din = din; v.rd = rd; v.wr = wr;
    v.addr = addr; v.hi = hi; v.dout = dout; v.dw = dw;
    return v;
  endfunction

  task automatic apply(input string name, input vec_t v);
    step(v.cs, v.bs, v.din);
    chk(name, dut_vec(), {v.rd, v.wr, v.addr, v.hi, v.dout, v.dw});
  endtask

  vec_t vt[$];
  vec_t hv[$];

  initial begin
    bus.cs_n = 1; bus.byte_sync = 0; bus.data_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", dut_vec(), 25'd0);
    rf_clr = 0;
    rst_n = 1;

    //            cs bs din    rd wr addr  hi dout   dw
    vt.push_back(mkv(0,1,8'h85, 0,0,6'h05,0,8'h00,8'h00)); // write cmd
    vt.push_back(mkv(0,0,8'h00, 0,0,6'h05,0,8'h00,8'h00));
    vt.push_back(mkv(0,1,8'h3C, 0,1,6'h05,0,8'h00,8'h3C)); // write strobe
    vt.push_back(mkv(0,0,8'h00, 0,0,6'h05,0,8'h00,8'h3C));
    vt.push_back(mkv(0,1,8'h45, 1,0,6'h05,1,8'h00,8'h3C)); // read strobe
    vt.push_back(mkv(0,0,8'h00, 0,0,6'h05,1,8'hA7,8'h3C)); // data_out valid
    vt.push_back(mkv(0,1,8'h00, 0,0,6'h05,1,8'hA7,8'h3C)); // dummy byte
    vt.push_back(mkv(0,1,8'h82, 0,0,6'h02,0,8'hA7,8'h3C)); // write cmd
    vt.push_back(mkv(1,0,8'h00, 0,0,6'h02,0,8'hA7,8'h3C)); // abort
    vt.push_back(mkv(0,1,8'h82, 0,0,6'h02,0,8'hA7,8'h3C));
    vt.push_back(mkv(0,1,8'h11, 0,1,6'h02,0,8'hA7,8'h11));
    vt.push_back(mkv(0,0,8'h00, 0,0,6'h02,0,8'hA7,8'h11));
    vt.push_back(mkv(0,1,8'h81, 0,0,6'h01,0,8'hA7,8'h11));
    vt.push_back(mkv(1,1,8'hFF, 0,1,6'h01,0,8'hA7,8'hFF)); // byte_sync + cs_n rise
    vt.push_back(mkv(1,0,8'h00, 0,0,6'h01,0,8'hA7,8'hFF));
    vt.push_back(mkv(0,1,8'h83, 0,0,6'h03,0,8'hA7,8'hFF)); // back in ST_CMD
    vt.push_back(mkv(0,1,8'h55, 0,1,6'h03,0,8'hA7,8'h55));
    vt.push_back(mkv(0,1,8'h03, 1,0,6'h03,0,8'hA7,8'h55)); // read back
    vt.push_back(mkv(0,0,8'h00, 0,0,6'h03,0,8'h55,8'h55));
    vt.push_back(mkv(0,1,8'h00, 0,0,6'h03,0,8'h55,8'h55));
    vt.push_back(mkv(0,1,8'h45, 1,0,6'h05,1,8'h55,8'h55));
    vt.push_back(mkv(1,1,8'h00, 0,0,6'h05,1,8'hA7,8'h55)); // ST_RD ignores both
    vt.push_back(mkv(0,1,8'hC4, 0,0,6'h05,1,8'hA7,8'h55)); // dummy
    vt.push_back(mkv(0,1,8'hC4, 0,0,6'h04,1,8'hA7,8'h55)); // write cmd
    vt.push_back(mkv(1,0,8'h00, 0,0,6'h04,1,8'hA7,8'h55)); // abort
    vt.push_back(mkv(0,1,8'h9A, 0,0,6'h1A,0,8'hA7,8'h55)); // now in ST_WDATA

    @(negedge clk);
    for (int i = 0; i < vt.size(); i++) apply($sformatf("vec%0d", i), vt[i]);

    // Reset while in ST_WDATA, then 0x01 must decode as a read command
    do_reset("reset_mid_wdata");
    hv.push_back(mkv(0,0,8'h00, 0,0,6'h00,0,8'h00,8'h00)); // no stray write
    hv.push_back(mkv(0,1,8'h01, 1,0,6'h01,0,8'h00,8'h00));
    hv.push_back(mkv(0,0,8'h00, 0,0,6'h01,0,8'hFF,8'h00));
    hv.push_back(mkv(0,1,8'h00, 0,0,6'h01,0,8'hFF,8'h00));
    for (int i = 0; i < hv.size(); i++) apply($sformatf("post_reset%0d", i), hv[i]);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset("rand_reset");
      end
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4, 8'($urandom));
      if (bus.read && bus.write) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_wr_excl: got read=1 write=1, want at most one high");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, want finish within bound");
    $fatal(1, "timeout");
  end

endmodule
